// File: rtl/math_fp_pkg.sv
// Shared IEEE-754 constants, FSM states and operand classification for the
// iterative float math units.
package math_fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    FP_NORMAL = 3'd0,
    FP_ZERO   = 3'd1,
    FP_SUB    = 3'd2,
    FP_INF    = 3'd3,
    FP_NAN    = 3'd4
  } fp_class_e;

  localparam int EW32 = 8;
  localparam int MW32 = 23;
  localparam int EW64 = 11;
  localparam int MW64 = 52;

  localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
  localparam logic [31:0] PINF32 = 32'h7F80_0000;
  localparam logic [31:0] NINF32 = 32'hFF80_0000;
  localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PINF64 = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF64 = 64'hFFF0_0000_0000_0000;

  function automatic int fp_ew(input int width);
    return (width == 64) ? EW64 : EW32;
  endfunction

  function automatic int fp_mw(input int width);
    return (width == 64) ? MW64 : MW32;
  endfunction

  function automatic int fp_bias(input int width);
    return (1 << (fp_ew(width) - 1)) - 1;
  endfunction

  function automatic logic [63:0] fp_qnan(input int width);
    return (width == 64) ? QNAN64 : {32'h0000_0000, QNAN32};
  endfunction

  function automatic logic [63:0] fp_pinf(input int width);
    return (width == 64) ? PINF64 : {32'h0000_0000, PINF32};
  endfunction

  function automatic logic [63:0] fp_ninf(input int width);
    return (width == 64) ? NINF64 : {32'h0000_0000, NINF32};
  endfunction

  function automatic fp_class_e fp_unpack_class(input logic exp_zero,
                                                input logic exp_ones,
                                                input logic man_zero);
    if (exp_ones) begin
      return man_zero ? FP_INF : FP_NAN;
    end else if (exp_zero) begin
      return man_zero ? FP_ZERO : FP_SUB;
    end else begin
      return FP_NORMAL;
    end
  endfunction

endpackage

// File: rtl/math_log2_iter_if.sv
// Operand/result handshake bundle for math_log2_iter.
interface math_log2_iter_if #(parameter int WIDTH = 32) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_invalid;
  logic             flag_divzero;

  modport master (output in_valid, a, out_ready,
                  input  in_ready, out_valid, result, flag_invalid, flag_divzero);
  modport slave  (input  in_valid, a, out_ready,
                  output in_ready, out_valid, result, flag_invalid, flag_divzero);
endinterface

// File: rtl/math_fx2fp_norm.sv
// Combinational signed fixed-point (FRAC_BITS fraction bits) to IEEE float
// converter; mantissa bits beyond MW are truncated toward zero.
module math_fx2fp_norm
  import math_fp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int IN_W      = 33,
  parameter int FRAC_BITS = 24
) (
  input  logic [IN_W-1:0]  fx_i,
  output logic [WIDTH-1:0] fp_o
);
  localparam int EW   = fp_ew(WIDTH);
  localparam int MW   = fp_mw(WIDTH);
  localparam int BIAS = fp_bias(WIDTH);

  logic            neg_s;
  logic [IN_W-1:0] mag_s;
  logic [IN_W-1:0] aligned_s;
  int              lead_s;
  logic [EW-1:0]   exp_s;
  logic [MW-1:0]   man_s;

  // Magnitude, leading-one detect, left-align and pack.
  always_comb begin
    neg_s  = fx_i[IN_W-1];
    mag_s  = neg_s ? (~fx_i + IN_W'(1'b1)) : fx_i;
    lead_s = 0;
    for (int i = 0; i < IN_W; i++) begin
      if (mag_s[i]) begin
        lead_s = i;
      end else begin
        lead_s = lead_s;
      end
    end
    aligned_s = mag_s << (IN_W - 1 - lead_s);
    // Leading one lands on bit MW and is dropped by the cast.
    man_s = MW'({aligned_s, {MW{1'b0}}} >> (IN_W - 1));
    exp_s = EW'(lead_s - FRAC_BITS + BIAS);
    if (fx_i == '0) begin
      fp_o = '0;
    end else begin
      fp_o = {neg_s, exp_s, man_s};
    end
  end

endmodule

// File: rtl/math_log2_iter.sv
// Iterative IEEE-754 log2: one fraction bit per cycle by repeated mantissa
// squaring, then fixed-point to float normalization.
module math_log2_iter
  import math_fp_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FRAC_BITS = 24
) (
  input logic            clk,
  input logic            rst,
  math_log2_iter_if.slave io
);
  localparam int EW   = fp_ew(WIDTH);
  localparam int MW   = fp_mw(WIDTH);
  localparam int BIAS = fp_bias(WIDTH);
  localparam int XW   = MW + 1;
  localparam int VW   = EW + 1 + FRAC_BITS;
  localparam int CW   = $clog2(FRAC_BITS + 1);

  localparam logic [EW:0]      BIAS_V   = (EW+1)'(BIAS);
  localparam logic [CW-1:0]    CNT_LAST = CW'(FRAC_BITS - 1);
  localparam logic [WIDTH-1:0] QNAN_V   = WIDTH'(fp_qnan(WIDTH));
  localparam logic [WIDTH-1:0] PINF_V   = WIDTH'(fp_pinf(WIDTH));
  localparam logic [WIDTH-1:0] NINF_V   = WIDTH'(fp_ninf(WIDTH));

  if (WIDTH != 32 && WIDTH != 64) begin : g_bad_width
    $fatal(1, "math_log2_iter: WIDTH must be 32 or 64");
  end
  if (FRAC_BITS < 1 || FRAC_BITS > 60) begin : g_bad_frac
    $fatal(1, "math_log2_iter: FRAC_BITS must be in 1..60");
  end

  state_e           state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [FRAC_BITS-1:0] f_q, f_d;
  logic [EW:0]      e_q, e_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             inv_q, inv_d;
  logic             dz_q, dz_d;

  logic             a_sign_s;
  logic [EW-1:0]    a_exp_s;
  logic [MW-1:0]    a_man_s;
  fp_class_e        a_class_s;
  logic [2*XW-1:0]  sq_s;
  logic             sq_bit_s;
  logic [XW-1:0]    x_next_s;
  logic [FRAC_BITS:0] f_shift_s;
  logic [WIDTH-1:0] norm_s;

  assign a_sign_s  = io.a[WIDTH-1];
  assign a_exp_s   = io.a[WIDTH-2 -: EW];
  assign a_man_s   = io.a[MW-1:0];
  assign a_class_s = fp_unpack_class(a_exp_s == '0, &a_exp_s, a_man_s == '0);

  // x holds a value in [1,2) with MW fraction bits; x*x lies in [1,4).
  assign sq_s      = {{XW{1'b0}}, x_q} * {{XW{1'b0}}, x_q};
  assign sq_bit_s  = sq_s[2*XW-1];
  assign x_next_s  = sq_bit_s ? XW'(sq_s >> XW) : XW'(sq_s >> (XW - 1));
  assign f_shift_s = {f_q, sq_bit_s};

  math_fx2fp_norm #(
    .WIDTH     (WIDTH),
    .IN_W      (VW),
    .FRAC_BITS (FRAC_BITS)
  ) u_norm (
    .fx_i ({e_q, f_q}),
    .fp_o (norm_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      f_q      <= '0;
      e_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      inv_q    <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      f_q      <= f_d;
      e_q      <= e_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      inv_q    <= inv_d;
      dz_q     <= dz_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    f_d      = f_q;
    e_d      = e_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    inv_d    = inv_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (io.in_valid) begin
          inv_d = 1'b0;
          dz_d  = 1'b0;
          if (a_class_s == FP_NAN || (a_sign_s && a_class_s != FP_ZERO)) begin
            result_d = QNAN_V;
            inv_d    = 1'b1;
            state_d  = ST_DONE;
          end else if (a_class_s == FP_ZERO || a_class_s == FP_SUB) begin
            result_d = NINF_V;
            dz_d     = 1'b1;
            state_d  = ST_DONE;
          end else if (a_class_s == FP_INF) begin
            result_d = PINF_V;
            state_d  = ST_DONE;
          end else begin
            e_d     = {1'b0, a_exp_s} - BIAS_V;
            x_d     = {1'b1, a_man_s};
            f_d     = '0;
            cnt_d   = '0;
            state_d = ST_ITER;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ITER: begin
        x_d   = x_next_s;
        f_d   = f_shift_s[FRAC_BITS-1:0];
        cnt_d = cnt_q + CW'(1'b1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_NORM;
        end else begin
          state_d = ST_ITER;
        end
      end
      ST_NORM: begin
        result_d = norm_s;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (io.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign io.in_ready     = (state_q == ST_IDLE);
  assign io.out_valid    = (state_q == ST_DONE);
  assign io.result       = result_q;
  assign io.flag_invalid = inv_q;
  assign io.flag_divzero = dz_q;

endmodule

// File: tb/tb_math_log2_iter.sv
// Randomized and directed bench for math_log2_iter (FP32/24 and FP64/53)
// against an arithmetic reference model.
module tb_math_log2_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  math_log2_iter_if #(.WIDTH(32)) if32 ();
  math_log2_iter_if #(.WIDTH(64)) if64 ();

  math_log2_iter #(.WIDTH(32), .FRAC_BITS(24)) dut32 (.clk(clk), .rst(rst), .io(if32));
  math_log2_iter #(.WIDTH(64), .FRAC_BITS(53)) dut64 (.clk(clk), .rst(rst), .io(if64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // log2 by squaring in exact integer arithmetic, result truncated toward zero.
  function automatic void ref_log2(input bit is64, input logic [63:0] av,
                                   output logic [63:0] res, output bit inv,
                                   output bit dz, output bit spec);
    int ew, mw, fb, bias, expf, k;
    bit sgn;
    logic [63:0] man, qnan, pinf, ninf;
    logic [127:0] x, sq, f, mag;
    logic signed [127:0] v;
    ew   = is64 ? 11 : 8;
    mw   = is64 ? 52 : 23;
    fb   = is64 ? 53 : 24;
    bias = (1 << (ew - 1)) - 1;
    sgn  = av[ew + mw];
    expf = int'((av >> mw) & ((64'd1 << ew) - 64'd1));
    man  = av & ((64'd1 << mw) - 64'd1);
    qnan = is64 ? 64'h7FF8_0000_0000_0000 : 64'h0000_0000_7FC0_0000;
    pinf = is64 ? 64'h7FF0_0000_0000_0000 : 64'h0000_0000_7F80_0000;
    ninf = is64 ? 64'hFFF0_0000_0000_0000 : 64'h0000_0000_FF80_0000;
    inv = 1'b0; dz = 1'b0; spec = 1'b1; res = 64'd0;
    if (expf == (1 << ew) - 1 && man != 64'd0) begin
      res = qnan; inv = 1'b1;
    end else if (sgn && (expf != 0 || man != 64'd0)) begin
      res = qnan; inv = 1'b1;
    end else if (expf == 0) begin
      res = ninf; dz = 1'b1;
    end else if (expf == (1 << ew) - 1) begin
      res = pinf;
    end else begin
      spec = 1'b0;
      x = 128'(man) | (128'd1 << mw);
      f = 128'd0;
      for (int i = 0; i < fb; i++) begin
        sq = x * x;
        f  = f << 1;
        if (sq >= (128'd2 << (2 * mw))) begin
          f = f | 128'd1;
          x = sq >> (mw + 1);
        end else begin
          x = sq >> mw;
        end
      end
      v = expf - bias;
      v = (v <<< fb) + $signed(f);
      if (v != 0) begin
        mag = (v < 0) ? -v : v;
        k = 0;
        for (int i = 0; i < 128; i++) if (mag >= (128'd1 << i)) k = i;
        res = ((v < 0) ? 64'd1 : 64'd0) << (ew + mw);
        res = res | (64'(k - fb + bias) << mw);
        res = res | 64'(((mag << mw) >> k) - (128'd1 << mw));
      end
    end
  endfunction

  function automatic logic cur_ov(input bit is64);
    return is64 ? if64.out_valid : if32.out_valid;
  endfunction

  task automatic run_op(input bit is64, input logic [63:0] av, input string tag,
                        output logic [63:0] got);
    logic [63:0] er;
    bit ei, ed, es;
    int lat;
    ref_log2(is64, av, er, ei, ed, es);
    @(negedge clk);
    if (is64) begin
      if64.a = av; if64.in_valid = 1'b1;
    end else begin
      if32.a = av[31:0]; if32.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    if64.in_valid = 1'b0;
    if32.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!cur_ov(is64) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    got = is64 ? if64.result : {32'h0, if32.result};
    chk({tag, ".lat"}, 64'(lat), es ? 64'd1 : (is64 ? 64'd55 : 64'd26));
    chk({tag, ".res"}, got, er);
    chk({tag, ".inv"}, is64 ? if64.flag_invalid : if32.flag_invalid, 64'(ei));
    chk({tag, ".dz"},  is64 ? if64.flag_divzero : if32.flag_divzero, 64'(ed));
  endtask

  initial begin
    logic [63:0] got, av, diff;
    if32.in_valid = 1'b0; if32.a = '0; if32.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.a = '0; if64.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.ov",  if32.out_valid, 64'd0);
    chk("rst.res", if32.result, 64'd0);
    chk("rst.inv", if32.flag_invalid, 64'd0);
    chk("rst.dz",  if32.flag_divzero, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.rdy", if32.in_ready, 64'd1);

    run_op(1'b0, 64'h4100_0000, "p8",   got); chk("p8.k",   got, 64'h4040_0000);
    run_op(1'b0, 64'h3F80_0000, "p1",   got); chk("p1.k",   got, 64'h0000_0000);
    run_op(1'b0, 64'h3F00_0000, "ph",   got); chk("ph.k",   got, 64'hBF80_0000);
    run_op(1'b0, 64'h4000_0000, "p2",   got); chk("p2.k",   got, 64'h3F80_0000);
    run_op(1'b0, 64'h0000_0000, "z",    got); chk("z.k",    got, 64'hFF80_0000);
    run_op(1'b0, 64'hBF80_0000, "neg",  got); chk("neg.k",  got, 64'h7FC0_0000);
    run_op(1'b0, 64'h7F80_0000, "inf",  got); chk("inf.k",  got, 64'h7F80_0000);
    run_op(1'b0, 64'h7FC0_0001, "nan",  got); chk("nan.k",  got, 64'h7FC0_0000);
    run_op(1'b0, 64'h0000_0001, "sub",  got); chk("sub.k",  got, 64'hFF80_0000);
    run_op(1'b0, 64'h3FC0_0000, "p1p5", got);
    diff = (got > 64'h3F15_C01A) ? got - 64'h3F15_C01A : 64'h3F15_C01A - got;
    chk("p1p5.ulp", 64'(diff <= 64'd2), 64'd1);
    run_op(1'b1, 64'h4090_0000_0000_0000, "d1k", got);
    chk("d1k.k", got, 64'h4024_0000_0000_0000);

    for (int i = 0; i < 16; i++) begin
      av = {32'h0, $urandom()};
      if ($urandom_range(0, 3) != 0) av[31] = 1'b0;
      run_op(1'b0, av, $sformatf("r32_%0d", i), got);
    end
    for (int i = 0; i < 5; i++) begin
      av = {1'b0, 11'($urandom_range(1, 2046)), 20'($urandom()), 32'($urandom())};
      run_op(1'b1, av, $sformatf("r64_%0d", i), got);
    end

    // Backpressure: hold DONE, poke in_valid, then release.
    if32.out_ready = 1'b0;
    @(negedge clk);
    if32.a = 32'h4100_0000; if32.in_valid = 1'b1;
    @(posedge clk);
    #1 if32.in_valid = 1'b0;
    for (int i = 0; i < 100 && !if32.out_valid; i++) @(negedge clk);
    chk("bp.ov", if32.out_valid, 64'd1);
    for (int i = 0; i < 10; i++) begin
      if32.a = 32'h4000_0000; if32.in_valid = 1'b1;
      @(negedge clk);
      chk("bp.res", if32.result, 64'h4040_0000);
      chk("bp.rdy", if32.in_ready, 64'd0);
      chk("bp.hold", if32.out_valid, 64'd1);
    end
    if32.in_valid = 1'b0;
    if32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.ov0", if32.out_valid, 64'd0);
    chk("bp.rdy1", if32.in_ready, 64'd1);
    @(negedge clk);
    chk("bp.idle", if32.in_ready, 64'd1);

    // Reset in the middle of an iteration.
    if32.a = 32'h3FC0_0000; if32.in_valid = 1'b1;
    @(posedge clk);
    #1 if32.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mr.busy", if32.in_ready, 64'd0);
    rst = 1'b1;
    #1;
    chk("mr.ov", if32.out_valid, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr.rdy", if32.in_ready, 64'd1);
    run_op(1'b0, 64'h4100_0000, "mr8", got); chk("mr8.k", got, 64'h4040_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
